// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard and sequencing unit: runs the two-round LDW/SDW sequence, detects load-use
// hazards, selects forwarding sources and flags illegal double-word encodings.
module hazard_stall_unit #(
    parameter int REG_W     = 4,
    parameter int OP_W      = 6,
    parameter int EXC_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      opcode_id,
    input  logic [REG_W-1:0]     rs_id,
    input  logic [REG_W-1:0]     rt_id,
    input  logic [REG_W-1:0]     rd_id,
    input  logic                 flush_id,
    input  logic [REG_W-1:0]     ex_rd,
    input  logic [REG_W-1:0]     mem_rd,
    input  logic [REG_W-1:0]     wb_rd,
    input  logic                 ex_regwr,
    input  logic                 mem_regwr,
    input  logic                 wb_regwr,
    input  logic                 ex_memrd,
    output logic                 stall,
    output logic                 pc_hold,
    output logic                 ifid_hold,
    output logic [1:0]           ForwardA,
    output logic [1:0]           ForwardB,
    output logic                 Exception,
    output logic                 round2,
    output logic [EXC_CNT_W-1:0] exc_count
);

    localparam logic [OP_W-1:0] OP_SW  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_LDW = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SDW = OP_W'(9);
    localparam logic [EXC_CNT_W-1:0] EXC_MAX = {EXC_CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ROUND2 = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [EXC_CNT_W-1:0]   exc_count_r;

    logic                   is_dw_s;
    logic                   illegal_s;
    logic                   load_use_s;
    logic [REG_W-1:0]       src_b_s;
    logic                   stall_s;
    logic                   hold_s;
    logic                   exception_s;
    logic                   round2_s;
    logic [1:0]             fwd_a_s;
    logic [1:0]             fwd_b_s;

    // Forward select for one source. A load in EX only reports an EX match while it is causing
    // the load-use bubble, so the control unit can spot the LDW base-register case.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] e_rd,
        input logic             e_wr,
        input logic             e_ld,
        input logic             lu,
        input logic [REG_W-1:0] m_rd,
        input logic             m_wr,
        input logic [REG_W-1:0] w_rd,
        input logic             w_wr
    );
        logic [1:0] sel;
        if (e_wr && (e_rd == src) && (!e_ld || lu)) begin
            sel = 2'd1;
        end else if (m_wr && (m_rd == src)) begin
            sel = 2'd2;
        end else if (w_wr && (w_rd == src)) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Source-B register; SDW round 2 reads the odd half of the register pair.
    always_comb begin
        src_b_s = rt_id;
        if (opcode_id == OP_SW) begin
            src_b_s = rd_id;
        end else if (opcode_id == OP_SDW) begin
            if (state_r == ROUND2) begin
                src_b_s = {rd_id[REG_W-1:1], 1'b1};
            end else begin
                src_b_s = rd_id;
            end
        end else begin
            src_b_s = rt_id;
        end
    end

    assign is_dw_s    = (opcode_id == OP_LDW) || (opcode_id == OP_SDW);
    assign illegal_s  = (state_r == IDLE) && is_dw_s &&
                        (rd_id[0] || ((opcode_id == OP_LDW) && (rs_id == rd_id)));
    assign load_use_s = (state_r == IDLE) && ex_memrd && ex_regwr &&
                        ((ex_rd == rs_id) || (ex_rd == src_b_s));

    // Per-source forwarding selects, independent of the stall/sequence priority chain.
    always_comb begin
        fwd_a_s = fwd_sel(rs_id, ex_rd, ex_regwr, ex_memrd, load_use_s,
                          mem_rd, mem_regwr, wb_rd, wb_regwr);
        fwd_b_s = fwd_sel(src_b_s, ex_rd, ex_regwr, ex_memrd, load_use_s,
                          mem_rd, mem_regwr, wb_rd, wb_regwr);
    end

    // Sequencing priority: flush, round 2, illegal encoding, load-use, double-word start.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        hold_s      = 1'b0;
        exception_s = 1'b0;
        round2_s    = 1'b0;
        if (flush_id) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                ROUND2: begin
                    round2_s    = 1'b1;
                    state_nxt_s = IDLE;
                end
                IDLE: begin
                    if (illegal_s) begin
                        exception_s = 1'b1;
                    end else if (load_use_s) begin
                        stall_s = 1'b1;
                        hold_s  = 1'b1;
                    end else if (is_dw_s) begin
                        stall_s     = 1'b1;
                        hold_s      = 1'b1;
                        state_nxt_s = ROUND2;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Saturating count of cycles that raised Exception.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_count_r <= {EXC_CNT_W{1'b0}};
        end else if (exception_s && (exc_count_r != EXC_MAX)) begin
            exc_count_r <= exc_count_r + EXC_CNT_W'(1);
        end else begin
            exc_count_r <= exc_count_r;
        end
    end

    assign stall     = stall_s;
    assign pc_hold   = hold_s;
    assign ifid_hold = hold_s;
    assign Exception = exception_s;
    assign round2    = round2_s;
    assign ForwardA  = fwd_a_s;
    assign ForwardB  = fwd_b_s;
    assign exc_count = exc_count_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit; inputs change just after posedge, outputs are
// sampled on the falling edge.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode_id;
    logic [3:0] rs_id, rt_id, rd_id;
    logic       flush_id;
    logic [3:0] ex_rd, mem_rd, wb_rd;
    logic       ex_regwr, mem_regwr, wb_regwr, ex_memrd;
    logic       stall, pc_hold, ifid_hold, Exception, round2;
    logic [1:0] ForwardA, ForwardB;
    logic [7:0] exc_count;

    int n_vec = 0;
    int n_err = 0;

    hazard_stall_unit #(.REG_W(4), .OP_W(6), .EXC_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .flush_id(flush_id),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .wb_regwr(wb_regwr),
        .ex_memrd(ex_memrd),
        .stall(stall), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .Exception(Exception), .round2(round2), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        opcode_id = 6'd0; rs_id = 4'd0; rt_id = 4'd0; rd_id = 4'd0; flush_id = 1'b0;
        ex_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0;
        ex_regwr = 1'b0; mem_regwr = 1'b0; wb_regwr = 1'b0; ex_memrd = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        #2;
        check_val("rst_stall", stall, 0);
        check_val("rst_hold", {pc_hold, ifid_hold}, 0);
        check_val("rst_exc", Exception, 0);
        check_val("rst_round2", round2, 0);
        check_val("rst_fwd", {ForwardA, ForwardB}, 0);
        check_val("rst_cnt", exc_count, 0);
        next_cycle();
        rst_n = 1'b1;

        // LDW rd=4 rs=2: two cycles in ID, then reset asserted mid-ROUND2
        opcode_id = 6'd8; rd_id = 4'd4; rs_id = 4'd2;
        @(negedge clk);
        check_val("ldw_c0_stall", stall, 1);
        check_val("ldw_c0_hold", {pc_hold, ifid_hold}, 2'b11);
        check_val("ldw_c0_r2", round2, 0);
        next_cycle();
        @(negedge clk);
        check_val("ldw_c1_r2", round2, 1);
        check_val("ldw_c1_stall", stall, 0);
        check_val("ldw_c1_hold", {pc_hold, ifid_hold}, 2'b00);
        rst_n = 1'b0;
        #1;
        check_val("rstmid_r2", round2, 0);
        check_val("rstmid_cnt", exc_count, 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_stall", stall, 1);
        next_cycle();
        @(negedge clk);
        check_val("post_rst_r2", round2, 1);
        next_cycle();
        opcode_id = 6'd0;
        @(negedge clk);
        check_val("ldw_c2_idle", {stall, round2}, 0);

        // load-use: LW R3 in EX, ADD rs=3 in ID
        next_cycle();
        clear_inputs();
        ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 4'd3; rs_id = 4'd3; rt_id = 4'd1;
        @(negedge clk);
        check_val("lu_stall", stall, 1);
        check_val("lu_hold", {pc_hold, ifid_hold}, 2'b11);
        check_val("lu_fwdA", ForwardA, 1);
        check_val("lu_fwdB", ForwardB, 0);
        next_cycle();
        ex_memrd = 1'b0; ex_regwr = 1'b0; mem_rd = 4'd3; mem_regwr = 1'b1;
        @(negedge clk);
        check_val("lu_next_stall", stall, 0);
        check_val("lu_next_fwdA", ForwardA, 2);

        // SDW rd=6 with WB writing R7: srcB 6 then 7
        next_cycle();
        clear_inputs();
        opcode_id = 6'd9; rd_id = 4'd6; rs_id = 4'd1; wb_rd = 4'd7; wb_regwr = 1'b1;
        @(negedge clk);
        check_val("sdw_r1_stall", stall, 1);
        check_val("sdw_r1_fwdB", ForwardB, 0);
        next_cycle();
        @(negedge clk);
        check_val("sdw_r2_r2", round2, 1);
        check_val("sdw_r2_fwdB", ForwardB, 3);
        check_val("sdw_r2_stall", stall, 0);

        // SW uses rd as source B
        next_cycle();
        clear_inputs();
        opcode_id = 6'd7; rd_id = 4'd5; rt_id = 4'd2; mem_rd = 4'd5; mem_regwr = 1'b1;
        @(negedge clk);
        check_val("sw_fwdB", ForwardB, 2);

        // load-use on LDW delays round 1: 3 cycles in ID
        next_cycle();
        clear_inputs();
        opcode_id = 6'd8; rd_id = 4'd4; rs_id = 4'd3;
        ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 4'd3;
        @(negedge clk);
        check_val("dwlu_c0", {stall, round2}, 2'b10);
        next_cycle();
        ex_memrd = 1'b0; ex_regwr = 1'b0;
        @(negedge clk);
        check_val("dwlu_c1", {stall, round2}, 2'b10);
        next_cycle();
        @(negedge clk);
        check_val("dwlu_c2", {stall, round2}, 2'b01);

        // illegal LDW rd=5, with a load-use also present: Exception wins
        next_cycle();
        clear_inputs();
        opcode_id = 6'd8; rd_id = 4'd5; rs_id = 4'd1;
        ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 4'd1;
        @(negedge clk);
        check_val("ill_exc", Exception, 1);
        check_val("ill_stall", {stall, pc_hold, ifid_hold}, 0);
        check_val("ill_cnt0", exc_count, 0);
        next_cycle();
        ex_memrd = 1'b0; ex_regwr = 1'b0;
        @(negedge clk);
        check_val("ill_cnt1", exc_count, 1);
        check_val("ill_r2", round2, 0);
        rd_id = 4'd4; rs_id = 4'd4;
        #1;
        check_val("ill_rs_eq_rd", Exception, 1);
        for (int i = 0; i < 300; i++) begin
            next_cycle();
        end
        @(negedge clk);
        check_val("ill_sat", exc_count, 255);

        // SDW rs==rd is legal; flush aborts ROUND2
        next_cycle();
        clear_inputs();
        opcode_id = 6'd9; rs_id = 4'd4; rd_id = 4'd4;
        @(negedge clk);
        check_val("sdw_rs_eq_rd", {Exception, stall}, 2'b01);
        next_cycle();
        rs_id = 4'd9; flush_id = 1'b1;
        ex_rd = 4'd9; mem_rd = 4'd9; wb_rd = 4'd9;
        ex_regwr = 1'b1; mem_regwr = 1'b1; wb_regwr = 1'b1;
        @(negedge clk);
        check_val("flush_r2", round2, 0);
        check_val("flush_stall", {stall, pc_hold, ifid_hold, Exception}, 0);
        check_val("flush_fwdA", ForwardA, 1);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check_val("flush_idle", {stall, round2}, 0);
        check_val("cnt_hold", exc_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Decode-stage hazard and sequencing block. It drives the `stall`, `ForwardA`, `ForwardB` and `Exception` inputs of the control unit, and the hold/bubble controls of PC and IF/ID. It tracks the two-round LDW/SDW instructions with a small FSM, detects load-use hazards, selects forwarding sources, and flags illegal double-word encodings.

## Interface
Parameters:
- REG_W, 4, register-index width (16 GPRs)
- OP_W, 6, opcode width
- EXC_CNT_W, 8, width of saturating exception counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode_id  in  OP_W  opcode in IF/ID
- rs_id, rt_id, rd_id  in  REG_W  register fields in IF/ID
- flush_id  in  1  taken branch/jump kills the ID instruction
- ex_rd, mem_rd, wb_rd  in  REG_W  destination register in EX, MEM, WB
- ex_regwr, mem_regwr, wb_regwr  in  1  write-enable per stage
- ex_memrd  in  1  EX instruction is a load (LW or LDW round)
- stall  out  1  to control unit: round 1 of LDW/SDW, or load-use bubble
- pc_hold  out  1  freeze PC
- ifid_hold  out  1  freeze IF/ID
- ForwardA, ForwardB  out  2  0 regfile, 1 EX, 2 MEM, 3 WB
- Exception  out  1  illegal LDW/SDW; control unit emits a NOP
- round2  out  1  ID holds round 2 of a double-word instruction
- exc_count  out  EXC_CNT_W  saturating count of Exception cycles

## Operation
- Double-word opcodes: LDW = 8, SDW = 9. Single-word store: SW = 7.
- FSM states:
  - IDLE: reset state.
  - ROUND2: round 1 has issued and IF/ID holds the same instruction.
- Source B register (srcB):
  - SW, and SDW in IDLE: rd_id.
  - SDW in ROUND2: rd_id | 1.
  - All others: rt_id.
- Illegal encoding: the ID opcode is 8 or 9 in IDLE and either rd_id[0] == 1, or (opcode 8 and rs_id == rd_id).
  - Exception = 1; stall, pc_hold and ifid_hold = 0; state stays IDLE.
- Load-use hazard (IDLE only): ex_memrd & ex_regwr & (ex_rd == rs_id | ex_rd == srcB).
  - stall = pc_hold = ifid_hold = 1; state stays IDLE.
  - The control unit receives stall with a non-DW opcode, or ForwardA/B == 1, and issues a bubble.
- Double-word start: IDLE, opcode 8/9, legal, no load-use hazard.
  - stall = pc_hold = ifid_hold = 1; next state ROUND2.
- In ROUND2:
  - stall = 0, round2 = 1, pc_hold = ifid_hold = 0; next state IDLE.
  - No load-use stall is generated; forwarding only.
- Priority, highest first: flush_id, Exception, load-use, double-word start.
- flush_id = 1: all outputs except Forward*/exc_count are 0, and next state is IDLE. This holds in either state (it aborts ROUND2).
- Forwarding for each source:
  - Matches are independent per source.
  - 1 if ex_regwr & ex_rd == src & !ex_memrd.
  - Else 2 if mem_regwr & mem_rd == src.
  - Else 3 if wb_regwr & wb_rd == src.
  - Else 0.
  - ForwardA uses rs_id; ForwardB uses srcB.
  - During a load-use stall, the EX match on the load is still reported as 1, so the control unit can detect the LDW base-register case.
  - R0 is not special-cased.
- exc_count: increments on each clock with Exception = 1, and saturates at all-ones.

## Timing
- All outputs are combinational from state and inputs; only state and exc_count are registered.
- Reset (rst_n low, asynchronous): state = IDLE, exc_count = 0.
  - With idle inputs, all outputs are 0 and round2 = 0.
  - Reset asserted in ROUND2 returns to IDLE immediately, with no round 2 issued.
- LDW/SDW occupies ID for exactly 2 cycles: cycle N stall = 1, cycle N+1 round2 = 1. The PC advances after N+1.
- Load-use inserts exactly 1 bubble. In the next cycle the load is in MEM, so the forward select is 2 and there is no stall.
- A load-use hazard on a DW instruction delays its round 1 by one cycle; the total in ID is 3 cycles.
- Back-to-back LDW: the second LDW sees IDLE after the first's ROUND2 and starts its own sequence.

## Test plan
- Reset: rst_n = 0 mid-ROUND2 with opcode_id = 8 → state IDLE, round2 = 0, exc_count = 0. After release, LDW rd = 4 gives stall = 1.
- LDW rd = 4, rs = 2, no hazards → cycle 0: stall = 1, pc_hold = 1. Cycle 1: round2 = 1, stall = 0. Cycle 2: IDLE.
- LW R3 in EX (ex_memrd = 1, ex_rd = 3), ADD rs = 3 in ID → stall = 1, ForwardA = 1 for 1 cycle. Next cycle (mem_rd = 3): stall = 0, ForwardA = 2.
- SDW rd = 6; wb_rd = 7, wb_regwr = 1 → round 1: ForwardB = 0 (srcB = 6). Round 2: ForwardB = 3 (srcB = 7).
- LDW rd = 5 → Exception = 1, stall = 0, exc_count 0 → 1. Hold the instruction for 300 cycles → exc_count saturates at 255.
- SDW start, then flush_id = 1 in ROUND2 → round2 = 0, stall = 0, next state IDLE. EX, MEM and WB all match rs = 9 → ForwardA = 1 (EX priority).
